pe_inject_scheduler: RTL and testbench

- Clocked scheduler that shares one PE's NoC injection port between two producers: the PE's partial-sum stream and its filter-forwarding stream.
- Enforces the dataflow order: NUM_PSUMS psum packets go to the adder node, then one filter-frame packet goes to the next PE in the ring, then the cycle repeats.
- Builds the 47-bit packets (ifm/filt flag, dest, src, payload) and holds them in a one-entry output register until the router accepts them.
- One instance sits between each PE and its router port.

---
 rtl/pe_noc_pkg.sv | 32 +++
 rtl/pkt_out_reg.sv | 37 +++
 rtl/pe_inject_scheduler.sv | 121 ++++++++++++
 tb/tb_pe_inject_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_noc_pkg.sv
// Shared NoC definitions for PE injection: packet field layout, ring address
// table and the injection scheduler state encoding.
package pe_noc_pkg;

  localparam int PKT_W    = 47;
  localparam int FLAG_BIT = 46;
  localparam int DEST_MSB = 45;
  localparam int DEST_LSB = 43;
  localparam int SRC_MSB  = 42;
  localparam int SRC_LSB  = 40;
  localparam int DATA_MSB = 39;
  localparam int DATA_LSB = 0;

  localparam logic [31:0] PSUM_PAD = 32'h0000_FFFF;

  typedef enum logic {S_PSUM, S_FILT} state_e;
  typedef enum logic {ADDR_THIS, ADDR_NEXT} addr_sel_e;

  // Ring of three PEs: each forwards filters to its successor's node address.
  function automatic logic [2:0] pe_addr(input int idx, input addr_sel_e which);
    logic [2:0] addr;
    addr = 3'd7;
    case (idx)
      0:       addr = (which == ADDR_THIS) ? 3'd3 : 3'd1;
      1:       addr = (which == ADDR_THIS) ? 3'd1 : 3'd0;
      2:       addr = (which == ADDR_THIS) ? 3'd0 : 3'd3;
      default: addr = 3'd7;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/pkt_out_reg.sv
// One-entry valid/ready holding register; a drain and a load may coincide,
// so it sustains one packet per cycle.
module pkt_out_reg #(
  parameter int WIDTH = 47
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             slot_free_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign slot_free_o = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // NOTE: non-blocking assignments keep every register reading pre-edge values;
  // the data register is reset too because its idle value is visible on the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_inject_scheduler.sv
// Shares one PE's NoC injection port: NUM_PSUMS psum packets to the adder,
// then one filter frame to the next PE in the ring, repeating.
module pe_inject_scheduler
  import pe_noc_pkg::*;
#(
  parameter int DWIDTH         = 8,
  parameter int PWIDTH         = 47,
  parameter int PE_INDEX       = 0,
  parameter int NUM_PSUMS      = 3,
  parameter int ADDER_ADDR     = 4,
  parameter int MAX_FWD_ROUNDS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                psum_valid,
  output logic                psum_ready,
  input  logic [DWIDTH-1:0]   psum_data,
  input  logic                filt_valid,
  output logic                filt_ready,
  input  logic [3*DWIDTH-1:0] filt_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PWIDTH-1:0]   out_packet,
  output logic [7:0]          round_cnt,
  output logic [3:0]          psum_idx
);

  generate
    if (PE_INDEX < 0 || PE_INDEX > 2) begin : g_bad_pe_index
      $error("pe_inject_scheduler: PE_INDEX must be 0..2");
    end
    if (PWIDTH != PKT_W || DWIDTH != 8) begin : g_bad_width
      $error("pe_inject_scheduler: packet layout needs PWIDTH=47 and DWIDTH=8");
    end
    if (NUM_PSUMS < 1 || NUM_PSUMS > 15) begin : g_bad_num_psums
      $error("pe_inject_scheduler: NUM_PSUMS must be 1..15");
    end
  endgenerate

  localparam logic [2:0] THIS_ADDR = pe_addr(PE_INDEX, ADDR_THIS);
  localparam logic [2:0] NEXT_ADDR = pe_addr(PE_INDEX, ADDR_NEXT);
  localparam logic [3:0] LAST_IDX  = 4'(NUM_PSUMS - 1);

  state_e      state_q;
  logic [3:0]  psum_idx_q;
  logic [7:0]  round_cnt_q;

  logic              slot_free;
  logic              psum_fire;
  logic              filt_fire;
  logic              fwd_frame;
  logic              load;
  logic [PWIDTH-1:0] load_pkt;

  assign psum_ready = (state_q == S_PSUM) && slot_free;
  assign filt_ready = (state_q == S_FILT) && slot_free;
  assign psum_fire  = psum_valid && psum_ready;
  assign filt_fire  = filt_valid && filt_ready;
  // Frames past the forwarding limit are still consumed so the round advances.
  assign fwd_frame  = int'(round_cnt_q) < MAX_FWD_ROUNDS;
  assign load       = psum_fire || (filt_fire && fwd_frame);

  // NOTE: load_pkt gets a full default first so no path through the block infers a latch.
  always_comb begin
    load_pkt = '0;
    if (state_q == S_PSUM) begin
      load_pkt[FLAG_BIT]          = 1'b1;
      load_pkt[DEST_MSB:DEST_LSB] = 3'(ADDER_ADDR);
      load_pkt[SRC_MSB:SRC_LSB]   = THIS_ADDR;
      load_pkt[DATA_MSB:DATA_LSB] = 40'({PSUM_PAD, psum_data});
    end else begin
      load_pkt[FLAG_BIT]          = 1'b0;
      load_pkt[DEST_MSB:DEST_LSB] = NEXT_ADDR;
      load_pkt[SRC_MSB:SRC_LSB]   = THIS_ADDR;
      load_pkt[DATA_MSB:DATA_LSB] = 40'(filt_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PSUM;
      psum_idx_q  <= '0;
      round_cnt_q <= '0;
    end else begin
      case (state_q)
        S_PSUM: begin
          if (psum_fire) begin
            if (psum_idx_q == LAST_IDX) begin
              psum_idx_q <= '0;
              state_q    <= S_FILT;
            end else begin
              psum_idx_q <= psum_idx_q + 4'd1;
            end
          end
        end
        S_FILT: begin
          if (filt_fire) begin
            if (round_cnt_q != 8'hFF) round_cnt_q <= round_cnt_q + 8'd1;
            state_q <= S_PSUM;
          end
        end
        default: state_q <= S_PSUM;
      endcase
    end
  end

  pkt_out_reg #(.WIDTH(PWIDTH)) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i (load_pkt),
    .slot_free_o (slot_free),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_packet)
  );

  assign round_cnt = round_cnt_q;
  assign psum_idx  = psum_idx_q;

endmodule

// File: tb/tb_pe_inject_scheduler.sv
// Scoreboard bench: two schedulers (ring positions 0 and 2) share stimulus;
// accepted transactions feed a transaction-level model, a monitor checks outputs.
module tb_pe_inject_scheduler;

  localparam int         NP    = 3;
  localparam int         MAXF  = 2;
  localparam logic [2:0] ADDER = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psum_valid = 1'b0;
  logic [7:0]  psum_data = '0;
  logic        filt_valid = 1'b0;
  logic [23:0] filt_data = '0;
  logic        out_ready;
  logic        rdy_fixed = 1'b1;
  logic        rdy_rand = 1'b1;
  bit          rdy_random = 1'b0;

  logic        psum_ready0, filt_ready0, out_valid0;
  logic [46:0] out_packet0;
  logic [7:0]  round_cnt0;
  logic [3:0]  psum_idx0;
  logic        psum_ready2, filt_ready2, out_valid2;
  logic [46:0] out_packet2;
  logic [7:0]  round_cnt2;
  logic [3:0]  psum_idx2;

  assign out_ready = rdy_random ? rdy_rand : rdy_fixed;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rdy_rand = 1'($urandom_range(0, 1));
  end

  pe_inject_scheduler #(
    .DWIDTH(8), .PWIDTH(47), .PE_INDEX(0), .NUM_PSUMS(NP),
    .ADDER_ADDR(4), .MAX_FWD_ROUNDS(MAXF)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .psum_valid(psum_valid), .psum_ready(psum_ready0), .psum_data(psum_data),
    .filt_valid(filt_valid), .filt_ready(filt_ready0), .filt_data(filt_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_packet(out_packet0),
    .round_cnt(round_cnt0), .psum_idx(psum_idx0)
  );

  pe_inject_scheduler #(
    .DWIDTH(8), .PWIDTH(47), .PE_INDEX(2), .NUM_PSUMS(NP),
    .ADDER_ADDR(4), .MAX_FWD_ROUNDS(MAXF)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .psum_valid(psum_valid), .psum_ready(psum_ready2), .psum_data(psum_data),
    .filt_valid(filt_valid), .filt_ready(filt_ready2), .filt_data(filt_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_packet(out_packet2),
    .round_cnt(round_cnt2), .psum_idx(psum_idx2)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [46:0] exp_q0[$];
  logic [46:0] exp_q2[$];
  int          m_sent = 0;   // psums accepted in the current round
  int          m_round = 0;  // completed rounds, saturating

  bit          stall_seen = 1'b0;
  logic [46:0] stall_pkt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] addr_this(input int pe);
    return (pe == 0) ? 3'd3 : (pe == 1) ? 3'd1 : 3'd0;
  endfunction

  function automatic logic [2:0] addr_next(input int pe);
    return (pe == 0) ? 3'd1 : (pe == 1) ? 3'd0 : 3'd3;
  endfunction

  function automatic logic [46:0] psum_pkt(input int pe, input logic [7:0] d);
    return {1'b1, ADDER, addr_this(pe), 32'h0000_FFFF, d};
  endfunction

  function automatic logic [46:0] filt_pkt(input int pe, input logic [23:0] f);
    return {1'b0, addr_next(pe), addr_this(pe), 16'h0000, f};
  endfunction

  // Transaction-level reference: each round is NP psums then one frame,
  // and only the first MAXF frames are forwarded.
  task automatic model_accept(input bit is_filt, input logic [23:0] d);
    check("order_filt_expected", 64'(is_filt), 64'(m_sent == NP));
    if (!is_filt) begin
      exp_q0.push_back(psum_pkt(0, d[7:0]));
      exp_q2.push_back(psum_pkt(2, d[7:0]));
      m_sent++;
    end else begin
      if (m_round < MAXF) begin
        exp_q0.push_back(filt_pkt(0, d));
        exp_q2.push_back(filt_pkt(2, d));
      end
      if (m_round < 255) m_round++;
      m_sent = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_seen) begin
        check("hold_valid", 64'(out_valid0), 64'd1);
        check("hold_pkt", 64'(out_packet0), 64'(stall_pkt));
      end
      check("ready_exclusive", 64'(psum_ready0 && filt_ready0), 64'd0);
      check("round_cnt_pe0", 64'(round_cnt0), 64'(m_round));
      check("round_cnt_pe2", 64'(round_cnt2), 64'(m_round));
      check("psum_idx_pe0", 64'(psum_idx0), 64'((m_sent == NP) ? 0 : m_sent));
      if (out_valid0 && out_ready) begin
        if (exp_q0.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pkt_pe0_unexpected: got %0h expected none at %0t", out_packet0, $time);
        end else begin
          check("pkt_pe0", 64'(out_packet0), 64'(exp_q0.pop_front()));
        end
      end
      if (out_valid2 && out_ready) begin
        if (exp_q2.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pkt_pe2_unexpected: got %0h expected none at %0t", out_packet2, $time);
        end else begin
          check("pkt_pe2", 64'(out_packet2), 64'(exp_q2.pop_front()));
        end
      end
      stall_seen = out_valid0 && !out_ready;
      stall_pkt  = out_packet0;
    end else begin
      stall_seen = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    psum_valid = 1'b0;
    filt_valid = 1'b0;
    exp_q0.delete();
    exp_q2.delete();
    m_sent  = 0;
    m_round = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_psum(input logic [7:0] d, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    psum_valid = 1'b1;
    psum_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (psum_ready0) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (ok) begin
      @(posedge clk);
      model_accept(1'b0, {16'h0000, d});
      #1;
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL psum_accept_timeout: got no accept expected accept of %0h", d);
    end
    psum_valid = 1'b0;
  endtask

  task automatic send_filt(input logic [23:0] f, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    filt_valid = 1'b1;
    filt_data  = f;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (filt_ready0) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (ok) begin
      @(posedge clk);
      model_accept(1'b1, f);
      #1;
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL filt_accept_timeout: got no accept expected accept of %0h", f);
    end
    filt_valid = 1'b0;
  endtask

  task automatic full_round(input logic [7:0] base, input logic [23:0] f);
    int w;
    for (int k = 0; k < NP; k++) send_psum(base + 8'(k), w);
    send_filt(f, w);
  endtask

  initial begin
    int w;
    int wf;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_out_packet", 64'(out_packet0), 64'd0);
    check("rst_psum_idx", 64'(psum_idx0), 64'd0);
    check("rst_round_cnt", 64'(round_cnt0), 64'd0);
    check("rst_psum_ready", 64'(psum_ready0), 64'd1);
    check("rst_filt_ready", 64'(filt_ready0), 64'd0);

    // Basic round at PE 0 and PE 2, with literal packet checks
    @(posedge clk);
    #1;
    send_psum(8'd5, w);
    @(negedge clk);
    check("t1_psum_pe0", 64'(out_packet0), 64'({1'b1, 3'd4, 3'd3, 32'h0000_FFFF, 8'd5}));
    check("t1_psum_pe2", 64'(out_packet2), 64'({1'b1, 3'd4, 3'd0, 32'h0000_FFFF, 8'd5}));
    @(posedge clk);
    #1;
    send_psum(8'd6, w);
    send_psum(8'd7, w);
    send_filt(24'h090807, w);
    @(negedge clk);
    check("t1_filt_pe0", 64'(out_packet0), 64'({1'b0, 3'd1, 3'd3, 16'h0000, 24'h090807}));
    check("t1_filt_pe2", 64'(out_packet2), 64'({1'b0, 3'd3, 3'd0, 16'h0000, 24'h090807}));
    check("t1_round_cnt", 64'(round_cnt0), 64'd1);

    // Backpressure: four stalled cycles after psum 5
    do_reset();
    rdy_fixed = 1'b0;
    send_psum(8'd5, w);
    psum_valid = 1'b1;
    psum_data  = 8'd6;
    repeat (4) begin
      @(negedge clk);
      check("bp_psum_ready", 64'(psum_ready0), 64'd0);
      check("bp_hold_pkt", 64'(out_packet0), 64'({1'b1, 3'd4, 3'd3, 32'h0000_FFFF, 8'd5}));
    end
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    send_psum(8'd6, w);
    check("bp_accept_same_cycle", 64'(w), 64'd0);
    send_psum(8'd7, w);
    send_filt(24'h010203, w);

    // Filter offered together with psum 1 waits for the third psum
    fork
      begin
        int wp;
        send_psum(8'd1, wp);
        send_psum(8'd2, wp);
        send_psum(8'd3, wp);
      end
      begin
        send_filt(24'h0a0b0c, wf);
      end
    join
    check("early_filt_waits", 64'(wf), 64'd3);

    // Drop after MAXF forwarded frames, with and without a pending packet
    do_reset();
    full_round(8'h10, 24'h111111);
    full_round(8'h20, 24'h222222);
    full_round(8'h30, 24'h333333);
    @(negedge clk);
    check("drop_out_valid", 64'(out_valid0), 64'd0);
    check("drop_round_cnt", 64'(round_cnt0), 64'd3);
    @(posedge clk);
    #1;
    for (int k = 0; k < NP; k++) send_psum(8'h40 + 8'(k), w);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send_filt(24'h444444, w);
    @(negedge clk);
    check("drop_idle_out_valid", 64'(out_valid0), 64'd0);
    check("drop_idle_round_cnt", 64'(round_cnt0), 64'd4);

    // Reset mid-round while a packet is stalled
    do_reset();
    send_psum(8'd1, w);
    send_psum(8'd2, w);
    rdy_fixed = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", 64'(out_valid0), 64'd1);
    do_reset();
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid0), 64'd0);
    check("mid_rst_psum_idx", 64'(psum_idx0), 64'd0);
    check("mid_rst_round_cnt", 64'(round_cnt0), 64'd0);
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    full_round(8'h50, 24'h555555);

    // Sustained back-to-back psums: one packet per cycle
    for (int k = 0; k < NP; k++) begin
      send_psum(8'h60 + 8'(k), w);
      check("burst_no_wait", 64'(w), 64'd0);
    end
    send_filt(24'h666666, w);

    // Randomized rounds with random router backpressure and producer gaps
    do_reset();
    rdy_random = 1'b1;
    for (int r = 0; r < 4; r++) begin
      fork
        begin
          int wp;
          for (int k = 0; k < NP; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send_psum(8'($urandom), wp);
          end
        end
        begin
          int wq;
          repeat ($urandom_range(0, 6)) begin
            @(posedge clk);
            #1;
          end
          send_filt(24'($urandom), wq);
        end
      join
    end
    rdy_random = 1'b0;
    rdy_fixed  = 1'b1;
    repeat (3) @(negedge clk);
    check("drained_pe0", 64'(exp_q0.size()), 64'd0);
    check("drained_pe2", 64'(exp_q2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
